// File: rtl/wb_stage_buf.sv
// Two-slot writeback stage buffer (main + skid) with registered outputs and WAW lane filtering.
// Optional macro WB_X0_FILTER_EN: drop rd_e for lanes writing address 0 at capture.
module wb_stage_buf #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LANES     = 2,
  parameter int STALL_W   = 6,
  parameter int STALL_IDX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_rd_data,
  input  logic [LANES*ADDR_W-1:0]   in_rd_addr,
  input  logic [LANES-1:0]          in_rd_e,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_rd_data,
  output logic [LANES*ADDR_W-1:0]   out_rd_addr,
  output logic [LANES-1:0]          out_rd_e,
  output logic [1:0]                occupancy
);

  // State encodes the number of valid slots; main is valid in ONE/TWO, skid only in TWO.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t state, state_nxt;

  logic [LANES*DATA_W-1:0] main_data, main_data_nxt, skid_data, skid_data_nxt;
  logic [LANES*ADDR_W-1:0] main_addr, main_addr_nxt, skid_addr, skid_addr_nxt;
  logic [LANES-1:0]        main_e, main_e_nxt, skid_e, skid_e_nxt;
  logic [LANES-1:0]        cap_e;

  logic main_valid, skid_valid;
  logic stall_here, stall_next, stall_freeze;
  logic accept, drain;
  logic stall_unused;

  assign main_valid = (state != EMPTY);
  assign skid_valid = (state == TWO);

  assign stall_here = stall[STALL_IDX];
  generate
    if (STALL_IDX < STALL_W - 1) begin : g_next_stage
      assign stall_next = stall[STALL_IDX+1];
    end else begin : g_last_stage
      assign stall_next = 1'b0;
    end
  endgenerate
  assign stall_freeze = stall_here & stall_next;
  assign stall_unused = ^stall;

  assign in_ready = !skid_valid & !stall_here;
  assign accept   = in_valid & in_ready & rdy;
  assign drain    = main_valid & out_ready & rdy;

  // Highest lane wins on duplicate destination addresses.
  always_comb begin
    cap_e = in_rd_e;
    for (int unsigned j = 0; j < LANES; j++) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (k > j && in_rd_e[k] &&
            in_rd_addr[k*ADDR_W +: ADDR_W] == in_rd_addr[j*ADDR_W +: ADDR_W])
          cap_e[j] = 1'b0;
      end
`ifdef WB_X0_FILTER_EN
      if (in_rd_addr[j*ADDR_W +: ADDR_W] == '0)
        cap_e[j] = 1'b0;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    main_data_nxt = main_data;
    main_addr_nxt = main_addr;
    main_e_nxt    = main_e;
    skid_data_nxt = skid_data;
    skid_addr_nxt = skid_addr;
    skid_e_nxt    = skid_e;

    if (rdy) begin
      if (flush) begin
        state_nxt     = EMPTY;
        main_data_nxt = '0;
        main_addr_nxt = '0;
        main_e_nxt    = '0;
        skid_data_nxt = '0;
        skid_addr_nxt = '0;
        skid_e_nxt    = '0;
      end else if (!stall_freeze) begin
        if (!main_valid || drain) begin
          if (skid_valid) begin
            // Promotion: in_ready was low, so no accept can collide here.
            state_nxt     = ONE;
            main_data_nxt = skid_data;
            main_addr_nxt = skid_addr;
            main_e_nxt    = skid_e;
            skid_data_nxt = '0;
            skid_addr_nxt = '0;
            skid_e_nxt    = '0;
          end else if (accept) begin
            state_nxt     = ONE;
            main_data_nxt = in_rd_data;
            main_addr_nxt = in_rd_addr;
            main_e_nxt    = cap_e;
          end else begin
            state_nxt     = EMPTY;
            main_data_nxt = '0;
            main_addr_nxt = '0;
            main_e_nxt    = '0;
          end
        end else if (accept) begin
          state_nxt     = TWO;
          skid_data_nxt = in_rd_data;
          skid_addr_nxt = in_rd_addr;
          skid_e_nxt    = cap_e;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_addr <= '0;
      main_e    <= '0;
      skid_data <= '0;
      skid_addr <= '0;
      skid_e    <= '0;
    end else begin
      state     <= state_nxt;
      main_data <= main_data_nxt;
      main_addr <= main_addr_nxt;
      main_e    <= main_e_nxt;
      skid_data <= skid_data_nxt;
      skid_addr <= skid_addr_nxt;
      skid_e    <= skid_e_nxt;
    end
  end

  assign out_valid   = main_valid;
  assign out_rd_data = main_data;
  assign out_rd_addr = main_addr;
  assign out_rd_e    = main_e;
  assign occupancy   = state;

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: directed scenarios plus random traffic against a queue-based model.
module tb_wb_stage_buf;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int L  = 2;
  localparam int SW = 6;
  localparam int SI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, rdy, flush, in_valid, in_ready, out_valid, out_ready;
  logic [SW-1:0]   stall;
  logic [L*DW-1:0] in_rd_data, out_rd_data;
  logic [L*AW-1:0] in_rd_addr, out_rd_addr;
  logic [L-1:0]    in_rd_e, out_rd_e;
  logic [1:0]      occupancy;

  wb_stage_buf #(.DATA_W(DW), .ADDR_W(AW), .LANES(L), .STALL_W(SW), .STALL_IDX(SI)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd_data(in_rd_data), .in_rd_addr(in_rd_addr), .in_rd_e(in_rd_e),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd_data(out_rd_data), .out_rd_addr(out_rd_addr), .out_rd_e(out_rd_e),
    .occupancy(occupancy)
  );

  typedef struct packed {
    logic [L*DW-1:0] d;
    logic [L*AW-1:0] a;
    logic [L-1:0]    e;
  } ent_t;

  ent_t q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scan lanes from the top, each address can be claimed once by an enabled lane.
  function automatic logic [L-1:0] ref_e(logic [L*AW-1:0] a, logic [L-1:0] e);
    logic [L-1:0] r;
    bit claimed [32];
    logic [AW-1:0] ad;
    r = '0;
    for (int i = 0; i < 32; i++) claimed[i] = 1'b0;
    for (int k = L - 1; k >= 0; k--) begin
      ad = a[k*AW +: AW];
      if (e[k] && !claimed[ad]) begin
        claimed[ad] = 1'b1;
        r[k] = 1'b1;
      end
`ifdef WB_X0_FILTER_EN
      if (ad == 0) r[k] = 1'b0;
`endif
    end
    return r;
  endfunction

  // Called at the negedge with inputs already set: check, advance one edge, update model.
  task automatic tick();
    ent_t h, ne;
    bit exp_ir, frz;
    h = (q.size() > 0) ? q[0] : '0;
    exp_ir = (q.size() < 2) && !stall[SI];
    #1;
    check("out_valid", out_valid, q.size() > 0);
    check("out_data", out_rd_data, h.d);
    check("out_addr", out_rd_addr, h.a);
    check("out_e", out_rd_e, h.e);
    check("occupancy", occupancy, q.size());
    check("in_ready", in_ready, exp_ir);
    frz = stall[SI] && stall[SI+1];
    @(posedge clk);
    if (rst) q.delete();
    else if (rdy) begin
      if (flush) q.delete();
      else if (!frz) begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && exp_ir) begin
          ne.d = in_rd_data;
          ne.a = in_rd_addr;
          ne.e = ref_e(in_rd_addr, in_rd_e);
          q.push_back(ne);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(logic [L*DW-1:0] d, logic [L*AW-1:0] a, logic [L-1:0] e);
    in_valid   = 1'b1;
    in_rd_data = d;
    in_rd_addr = a;
    in_rd_e    = e;
    tick();
    in_valid = 1'b0;
  endtask

  logic [L-1:0] exp_x0;

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_rd_data = '0; in_rd_addr = '0; in_rd_e = '0;
    @(negedge clk);
    in_valid = 1'b1; in_rd_e = 2'b11;
    tick();
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_occ", occupancy, 2'd0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    #1;

    // Single entry, one cycle latency
    out_ready = 1'b1;
    send({32'h0, 32'h1234}, {5'd0, 5'd3}, 2'b01);
    #1;
    check("lat_valid", out_valid, 1'b1);
    check("lat_data", out_rd_data[31:0], 32'h1234);
    check("lat_occ", occupancy, 2'd1);
    tick();

    // Fill both slots, then drain back to back
    out_ready = 1'b0;
    send({32'hA1, 32'hA0}, {5'd2, 5'd1}, 2'b11);
    send({32'hB1, 32'hB0}, {5'd5, 5'd4}, 2'b11);
    #1;
    check("fill_occ", occupancy, 2'd2);
    check("fill_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    tick();
    check("drain_b", out_rd_data[31:0], 32'hB0);
    tick();
    #1;
    check("drain_bubble", {out_valid, out_rd_data, out_rd_addr, out_rd_e}, '0);

    // WAW: both lanes target x7
    send({32'h2, 32'h1}, {5'd7, 5'd7}, 2'b11);
    #1;
    check("waw_e", out_rd_e, 2'b10);
    tick();

    // Stall this stage only: drain continues, input blocked
    out_ready = 1'b0;
    send({32'hC1, 32'hC0}, {5'd9, 5'd8}, 2'b11);
    stall = 6'b010000; out_ready = 1'b1;
    in_valid = 1'b1; in_rd_data = {32'hD1, 32'hD0}; in_rd_e = 2'b11;
    tick();
    #1;
    check("stall_bubble", {out_valid, out_rd_data}, '0);
    check("stall_in_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b0; stall = '0; out_ready = 1'b0;
    send({32'hE1, 32'hE0}, {5'd11, 5'd10}, 2'b11);
    stall = 6'b110000; out_ready = 1'b1;
    tick();
    tick();
    #1;
    check("freeze_data", out_rd_data[31:0], 32'hE0);
    stall = '0;
    tick();

    // Flush with two held entries
    out_ready = 1'b0;
    send({32'hF1, 32'hF0}, {5'd1, 5'd1}, 2'b01);
    send({32'hF3, 32'hF2}, {5'd2, 5'd2}, 2'b10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_occ", occupancy, 2'd0);
    check("flush_valid", out_valid, 1'b0);

    // rdy low: nothing moves
    send({32'h11, 32'h10}, {5'd3, 5'd3}, 2'b11);
    rdy = 1'b0; out_ready = 1'b1;
    send({32'h21, 32'h20}, {5'd4, 5'd4}, 2'b11);
    #1;
    check("rdy_hold", out_rd_data[31:0], 32'h10);
    rdy = 1'b1;
    tick();

    // Address zero on lane 0
    send({32'h0, 32'h55}, {5'd6, 5'd0}, 2'b01);
    #1;
`ifdef WB_X0_FILTER_EN
    exp_x0 = 2'b00;
`else
    exp_x0 = 2'b01;
`endif
    check("x0_e", out_rd_e, exp_x0);
    check("x0_data", out_rd_data[31:0], 32'h55);
    tick();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      rdy        = ($urandom_range(0, 19) != 0);
      flush      = ($urandom_range(0, 49) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      stall      = '0;
      stall[SI]  = ($urandom_range(0, 9) == 0);
      stall[SI+1]= ($urandom_range(0, 1) == 0);
      stall[0]   = $urandom_range(0, 1);
      in_rd_data = {$urandom, $urandom};
      in_rd_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      in_rd_e    = 2'($urandom_range(0, 3));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
